// File: rtl/uart_cmd_ctl.sv
// Host command controller: parses 'W' addr data / 'R' addr frames from the UART RX FIFO,
// executes them on an 8-bit register bank and returns one response byte. Optional inter-byte timeout: UART_CMD_TIMEOUT_EN.
module uart_cmd_ctl #(
    parameter int ADDR_W  = 3,
    parameter int TIMEOUT = 50_000_000,
    parameter int TO_W    = 26
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rx_empty,
    input  logic [7:0]                 r_data,
    output logic                       rd_uart,
    input  logic                       tx_full,
    output logic                       wr_uart,
    output logic [7:0]                 w_data,
    output logic [8*(2**ADDR_W)-1:0]   regs_flat,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       busy,
    output logic                       err
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] GET_ADDR = 3'd1;
    localparam logic [2:0] GET_DATA = 3'd2;
    localparam logic [2:0] EXEC     = 3'd3;
    localparam logic [2:0] SEND     = 3'd4;

    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_BAD = 8'h3F;

    // Configuration sanity hook: the counter must be able to reach TIMEOUT.
    if ((2**TO_W) <= TIMEOUT) begin : g_to_w_too_small
    end

    logic [2:0]        state, state_nxt;
    logic              is_wr;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    logic [7:0]        resp;
    logic              waiting, fetch, bad_op, to_hit;

    assign waiting = (state == GET_ADDR) || (state == GET_DATA);
    // rd_uart high means the FIFO flags are stale this cycle, so never fetch back-to-back.
    assign fetch   = ((state == IDLE) || waiting) && !rx_empty && !rd_uart;
    assign bad_op  = (state == IDLE) && fetch && (r_data != OP_WR) && (r_data != OP_RD);

`ifdef UART_CMD_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;

    assign to_hit = waiting && !fetch && (to_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            to_cnt <= '0;
        else if (!waiting || rd_uart || to_hit)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 1'b1;
    end
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (fetch) state_nxt = bad_op ? SEND : GET_ADDR;
            GET_ADDR: if (fetch) state_nxt = is_wr ? GET_DATA : EXEC;
            GET_DATA: if (fetch) state_nxt = EXEC;
            EXEC:     state_nxt = SEND;
            SEND:     if (!tx_full) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
        if (to_hit)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            rd_uart   <= 1'b0;
            wr_uart   <= 1'b0;
            w_data    <= 8'h00;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            err       <= 1'b0;
            regs_flat <= '0;
            is_wr     <= 1'b0;
            addr      <= '0;
            data      <= 8'h00;
            resp      <= 8'h00;
        end else begin
            state     <= state_nxt;
            busy      <= (state_nxt != IDLE);
            rd_uart   <= fetch;
            err       <= bad_op || to_hit;
            wr_strobe <= 1'b0;
            wr_uart   <= 1'b0;

            if (fetch) begin
                case (state)
                    IDLE: begin
                        is_wr <= (r_data == OP_WR);
                        if (bad_op)
                            resp <= RSP_BAD;
                    end
                    GET_ADDR: addr <= r_data[ADDR_W-1:0];
                    GET_DATA: data <= r_data;
                    default: ;
                endcase
            end

            if (state == EXEC) begin
                if (is_wr) begin
                    regs_flat[{addr, 3'b000} +: 8] <= data;
                    wr_strobe <= 1'b1;
                    wr_addr   <= addr;
                    resp      <= RSP_OK;
                end else begin
                    resp <= regs_flat[{addr, 3'b000} +: 8];
                end
            end

            if ((state == SEND) && !tx_full) begin
                wr_uart <= 1'b1;
                w_data  <= resp;
            end
        end
    end

endmodule

// File: doc/uart_cmd_ctl.md
# uart_cmd_ctl

Command controller that sits on the user side of the UART block (RX/TX FIFOs), parsing 2- or 3-byte command frames from the host and executing them against an internal register bank. It pops bytes from the RX FIFO, writes and reads a bank of 8-bit configuration registers, and pushes one response byte per frame into the TX FIFO. The register bank drives screen-control settings elsewhere in the design through a flat output bus and a write strobe.

## Interface
- ADDR_W, 3, register address width; bank holds 2^ADDR_W 8-bit registers
- TIMEOUT, 50_000_000, inter-byte timeout in clk cycles (used only with timeout feature)
- TO_W, 26, width of timeout counter; must satisfy 2^TO_W > TIMEOUT

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- rx_empty  in  1  UART RX FIFO empty
- r_data  in  8  UART RX FIFO head byte, valid while rx_empty=0
- rd_uart  out  1  one-cycle pop pulse to RX FIFO
- tx_full  in  1  UART TX FIFO full
- wr_uart  out  1  one-cycle push pulse to TX FIFO
- w_data  out  8  byte pushed with wr_uart
- regs_flat  out  8*2^ADDR_W  register bank, reg k at bits [8k+7:8k]
- wr_strobe  out  1  one-cycle pulse when a register is written
- wr_addr  out  ADDR_W  address of last write, valid with wr_strobe
- busy  out  1  high whenever state is not IDLE
- err  out  1  one-cycle pulse on bad opcode or timeout

## Operation
- Frame: opcode, address, [data]. Opcode 0x57 ('W') = write, 3 bytes; 0x52 ('R') = read, 2 bytes. Address uses bits [ADDR_W-1:0]; upper bits ignored.
- States: IDLE, GET_ADDR, GET_DATA, EXEC, SEND.
- Byte fetch (IDLE/GET_ADDR/GET_DATA): when rx_empty=0 and rd_uart=0, latch r_data and assert rd_uart next cycle. Never sample r_data or rx_empty while rd_uart=1 (FIFO flags lag the pop by one cycle).
- IDLE: fetched byte 'W' or 'R' -> GET_ADDR. Any other byte -> load response 0x3F ('?'), pulse err, -> SEND.
- GET_ADDR: fetch address; write -> GET_DATA, read -> EXEC.
- GET_DATA: fetch data -> EXEC.
- EXEC (one cycle): write: reg[addr] <= data, wr_strobe=1, wr_addr=addr, response 0x4B ('K'). Read: response = reg[addr]. -> SEND.
- SEND: when tx_full=0, assert wr_uart for one cycle with w_data=response, -> IDLE. While tx_full=1, hold in SEND; RX FIFO is not popped.
- Write of an address then read of same address in next frame returns the new value.
- Reset values: all registers 0x00, state IDLE, rd_uart=0, wr_uart=0, w_data=0x00, wr_strobe=0, wr_addr=0, busy=0, err=0. Reset mid-frame discards the partial frame; bytes already popped are lost, pending response is not sent.

## Timing
- All outputs registered.
- Byte fetch: rd_uart high the cycle after rx_empty=0 is seen; at most one pop per two cycles.
- Last frame byte latched at edge E: EXEC after E, register value visible on regs_flat and wr_strobe high in the cycle after edge E+1; wr_uart high in the cycle after edge E+2 if tx_full=0.
- Bad opcode: err and SEND entered together; wr_uart one cycle later if tx_full=0.
- Exactly one response byte per completed or rejected frame.

## Configuration
- UART_CMD_TIMEOUT_EN defined: counter clears on every pop; in GET_ADDR or GET_DATA, if TIMEOUT cycles elapse with no byte fetched, pulse err, return to IDLE, send no response. Counter idle (0) in other states.
- Not defined: no counter logic; GET_ADDR/GET_DATA wait indefinitely; err only on bad opcode. TIMEOUT and TO_W unused.

## Test plan
- Write: RX bytes 0x57,0x02,0xA5 -> regs_flat[23:16]=0xA5, one wr_strobe with wr_addr=2, one wr_uart with w_data=0x4B, three rd_uart pulses.
- Read-back: after above, RX 0x52,0x02 -> w_data=0xA5; RX 0x52,0x0A (ADDR_W=3) -> also 0xA5 (address aliasing).
- Bad opcode: RX 0x13 -> err pulse, w_data=0x3F, state back to IDLE; following valid frame executes normally.
- Backpressure: hold tx_full=1 during SEND of a write ack -> no wr_uart, no rd_uart of queued bytes; release -> exactly one 0x4B then next frame processed.
- Timeout (with UART_CMD_TIMEOUT_EN, TIMEOUT=100): RX 0x57 only -> err pulse 100 cycles after pop, no wr_uart, busy=0; without macro -> busy stays 1.
- Reset mid-frame: RX 0x57,0x01, assert reset -> all outputs and registers 0, no response; next frame 0x52,0x01 returns 0x00.
